uart_tx_scheduler: RTL

//  Round-robin scheduler sharing the single UART transmitter among NUM_REQ byte-stream requesters
//  (e.g. pool-test channel dump, command echo, status reporter).
//  A grant is held for a whole frame, from the first byte to the byte flagged last.

---
 rtl/uart_tx_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//   Round-robin arbiter that shares one UART transmitter among NUM_REQ
//   byte-stream requesters. A grant is held for a whole frame, from its first
//   byte up to the byte flagged with req_last. Bytes are handed to uart_tx with
//   a one-cycle tx_send pulse. uart_tx reports that it is idle with the level
//   signal tx_ready.
//
// Ports
//   clk          system clock
//   reset_b      asynchronous active-low reset
//   req          per-requester "byte available"
//   req_data     byte of requester i at [8*i+7:8*i]
//   req_last     per-requester "this byte ends the frame"
//   ack          one-cycle pulse, requester i's byte was taken
//   grant        one-hot owner of the transmitter (0 when idle)
//   tx_data      byte to uart_tx (registered, stable between sends)
//   tx_send      one-cycle start pulse to uart_tx
//   tx_ready     uart_tx idle level
//   busy         high while a grant is held
//   timeout_err  sticky flag, a grant was revoked by timeout
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 10
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int                 IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]    TO_LIMIT = TO_W'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Requester index following idx, wrapping at NUM_REQ (works for non power-of-two counts).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            wrap_inc = {IDX_W{1'b0}};
        end else begin
            wrap_inc = idx + IDX_W'(1'b1);
        end
    endfunction

    // k-th position of the round-robin scan that starts at base.
    function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] base, input int k);
        int pos;
        pos = int'(base) + k;
        if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
        end else begin
            pos = pos + 0;
        end
        scan_idx = IDX_W'(pos);
    endfunction

    state_t               state_r, state_s;
    logic [IDX_W-1:0]     gidx_r, gidx_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_s;
    logic                 last_r, last_s;
    logic [TO_W-1:0]      to_cnt_r, to_cnt_s;
    logic [NUM_REQ-1:0]   ack_r, ack_s;
    logic [NUM_REQ-1:0]   grant_r, grant_s;
    logic [7:0]           tx_data_r, tx_data_s;
    logic                 tx_send_r, tx_send_s;
    logic                 busy_r, busy_s;
    logic                 timeout_err_r, timeout_err_s;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;

    // Round-robin pick: scan from the far end back to rr_ptr so the position closest to rr_ptr wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = {IDX_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_valid_s = pick_valid_s | req[scan_idx(rr_ptr_r, k)];
            pick_idx_s   = req[scan_idx(rr_ptr_r, k)] ? scan_idx(rr_ptr_r, k) : pick_idx_s;
        end
    end

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_s       = state_r;
        gidx_s        = gidx_r;
        rr_ptr_s      = rr_ptr_r;
        last_s        = last_r;
        to_cnt_s      = to_cnt_r;
        ack_s         = {NUM_REQ{1'b0}};
        grant_s       = grant_r;
        tx_data_s     = tx_data_r;
        tx_send_s     = 1'b0;
        busy_s        = busy_r;
        timeout_err_s = timeout_err_r;

        case (state_r)
            S_IDLE: begin
                if (pick_valid_s) begin
                    gidx_s   = pick_idx_s;
                    grant_s  = ONE_HOT0 << pick_idx_s;
                    busy_s   = 1'b1;
                    to_cnt_s = {TO_W{1'b0}};
                    state_s  = S_LOAD;
                end else begin
                    grant_s  = {NUM_REQ{1'b0}};
                    busy_s   = 1'b0;
                end
            end
            S_LOAD: begin
                if (tx_ready && req[gidx_r]) begin
                    // Byte, start pulse, ack and last flag all belong to the same accepted byte.
                    tx_data_s = req_data[{gidx_r, 3'b000} +: 8];
                    tx_send_s = 1'b1;
                    ack_s     = grant_r;
                    last_s    = req_last[gidx_r];
                    to_cnt_s  = {TO_W{1'b0}};
                    state_s   = S_GUARD;
                end else if (!req[gidx_r]) begin
                    // Only a silent owner ages the grant; back-pressure from uart_tx does not.
                    if (to_cnt_r == TO_LIMIT) begin
                        timeout_err_s = 1'b1;
                        grant_s       = {NUM_REQ{1'b0}};
                        busy_s        = 1'b0;
                        rr_ptr_s      = wrap_inc(gidx_r);
                        to_cnt_s      = {TO_W{1'b0}};
                        state_s       = S_IDLE;
                    end else begin
                        to_cnt_s      = to_cnt_r + TO_W'(1'b1);
                    end
                end else begin
                    to_cnt_s = to_cnt_r;
                end
            end
            S_GUARD: begin
                // uart_tx has not yet dropped tx_ready for the byte just sent.
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (tx_ready) begin
                    if (last_r) begin
                        grant_s  = {NUM_REQ{1'b0}};
                        busy_s   = 1'b0;
                        rr_ptr_s = wrap_inc(gidx_r);
                        state_s  = S_IDLE;
                    end else begin
                        state_s  = S_LOAD;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: begin
                grant_s = {NUM_REQ{1'b0}};
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r       <= S_IDLE;
            gidx_r        <= {IDX_W{1'b0}};
            rr_ptr_r      <= {IDX_W{1'b0}};
            last_r        <= 1'b0;
            to_cnt_r      <= {TO_W{1'b0}};
            ack_r         <= {NUM_REQ{1'b0}};
            grant_r       <= {NUM_REQ{1'b0}};
            tx_data_r     <= 8'h00;
            tx_send_r     <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            gidx_r        <= gidx_s;
            rr_ptr_r      <= rr_ptr_s;
            last_r        <= last_s;
            to_cnt_r      <= to_cnt_s;
            ack_r         <= ack_s;
            grant_r       <= grant_s;
            tx_data_r     <= tx_data_s;
            tx_send_r     <= tx_send_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign ack         = ack_r;
    assign grant       = grant_r;
    assign tx_data     = tx_data_r;
    assign tx_send     = tx_send_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule
